// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the function-ROM window arbiter.
//   arb_state_e  : arbiter FSM states (idle, ROM window, guard gap)
//   DEF_*        : default window/guard lengths and requester ceiling
//   clog2_min1   : index/counter width helper that never returns 0
package rom_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WINDOW = 2'd1,
    S_GUARD  = 2'd2
  } arb_state_e;

  localparam int DEF_WINDOW = 14;
  localparam int DEF_GUARD  = 1;
  localparam int MAX_REQ    = 8;

  // Width needed to hold 0..v-1, but at least one bit so N=1 still has a port.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   req    : level requests, one bit per requester
//   ptr    : index of the previous owner; search starts at ptr+1
//   winner : first requesting index found going upward with wrap-around
//   valid  : at least one request is set
module rr_priority_picker
  import rom_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW   = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit overwrites last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (req[idx]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_window_arbiter.sv
// Shares the function ROM/MUX path between N_REQ requesters. Each grant owns
// the ROM for WINDOW cycles, followed by GUARD idle cycles, then the next
// owner is chosen round-robin.
//   Clk      : system clock, rising edge
//   Clear    : asynchronous active-high reset
//   req      : level request per requester
//   grant    : one-hot owner during the window, zero otherwise
//   grant_id : binary index of current/last owner (MUX select)
//   ROMsel   : high for exactly WINDOW cycles per grant
//   done     : one-cycle one-hot pulse to the owner as its window ends
//   busy     : high while in WINDOW or GUARD
module rom_window_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WINDOW = DEF_WINDOW,
  parameter int GUARD  = DEF_GUARD,
  localparam int IW    = clog2_min1(N_REQ),
  localparam int CW    = clog2_min1(WINDOW),
  localparam int GW    = clog2_min1(GUARD)
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_id,
  output logic             ROMsel,
  output logic [N_REQ-1:0] done,
  output logic             busy
);

  arb_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gid_q, gid_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             romsel_q, romsel_d;
  logic             busy_q, busy_d;

  logic [IW-1:0]    pick;
  logic             pick_vld;

  rr_priority_picker #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick),
    .valid  (pick_vld)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    gcnt_d   = gcnt_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    grant_d  = grant_q;
    romsel_d = romsel_q;
    busy_d   = busy_q;
    done_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d  = S_WINDOW;
          grant_d  = N_REQ'(1) << pick;
          gid_d    = pick;
          ptr_d    = pick;
          romsel_d = 1'b1;
          busy_d   = 1'b1;
          count_d  = '0;
        end
      end
      S_WINDOW: begin
        // Requests are ignored here: the window always runs full length.
        if (count_q == CW'(WINDOW - 1)) begin
          romsel_d = 1'b0;
          grant_d  = '0;
          done_d   = grant_q;
          count_d  = '0;
          if (GUARD > 0) begin
            state_d = S_GUARD;
            gcnt_d  = '0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_GUARD: begin
        if (gcnt_q == GW'(GUARD - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        romsel_d = 1'b0;
        grant_d  = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Pointer resets to the last index so requester 0 has first priority.
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      gcnt_q   <= '0;
      ptr_q    <= IW'(N_REQ - 1);
      gid_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      romsel_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      gcnt_q   <= gcnt_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      romsel_q <= romsel_d;
      busy_q   <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = gid_q;
  assign ROMsel   = romsel_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rom_window_arbiter.sv
module tb_rom_window_arbiter;

  logic       Clk = 1'b0;
  logic       Clear = 1'b0;

  logic [3:0] req = '0;
  logic [3:0] grant, done;
  logic [1:0] grant_id;
  logic       ROMsel, busy;

  logic [3:0] req_w1 = '0;
  logic [3:0] grant_w1, done_w1;
  logic [1:0] gid_w1;
  logic       rom_w1, busy_w1;

  logic [0:0] req_n1 = '0;
  logic [0:0] grant_n1, done_n1, gid_n1;
  logic       rom_n1, busy_n1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 Clk = ~Clk;

  rom_window_arbiter #(.N_REQ(4), .WINDOW(14), .GUARD(1)) u_dut (
    .Clk(Clk), .Clear(Clear), .req(req), .grant(grant), .grant_id(grant_id),
    .ROMsel(ROMsel), .done(done), .busy(busy)
  );

  rom_window_arbiter #(.N_REQ(4), .WINDOW(1), .GUARD(0)) u_w1 (
    .Clk(Clk), .Clear(Clear), .req(req_w1), .grant(grant_w1), .grant_id(gid_w1),
    .ROMsel(rom_w1), .done(done_w1), .busy(busy_w1)
  );

  rom_window_arbiter #(.N_REQ(1), .WINDOW(3), .GUARD(2)) u_n1 (
    .Clk(Clk), .Clear(Clear), .req(req_n1), .grant(grant_n1), .grant_id(gid_n1),
    .ROMsel(rom_n1), .done(done_n1), .busy(busy_n1)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Clear = 1'b1;
    repeat (2) step();
    Clear = 1'b0;
  endtask

  // Bounded wait for the main DUT to return to idle.
  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (!busy && !ROMsel) begin ok = 1'b1; break; end
    end
    chk_cnt++;
    if (ok !== 1'b1) $display("FAIL %s_idle_timeout: busy=%0b ROMsel=%0b", name, busy, ROMsel);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    #3;
    chk_cnt++;
    if ({grant, grant_id, ROMsel, done, busy} !== 12'h0)
      $display("FAIL reset_outputs: got %h want 000", {grant, grant_id, ROMsel, done, busy});
    else pass_cnt++;
    repeat (2) step();
    Clear = 1'b0;
  endtask

  task automatic test_idle();
    int bad = 0;
    do_reset();
    req = 4'b0000;
    repeat (50) begin
      step();
      if ({grant, grant_id, ROMsel, done, busy} !== 12'h0) bad++;
    end
    chk_cnt++;
    if (bad !== 0) $display("FAIL idle_quiet: %0d nonzero cycles, want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int hi = 1;
    do_reset();
    req = 4'b0010;
    step();
    chk_cnt++;
    if ({grant, grant_id, ROMsel, busy} !== {4'b0010, 2'd1, 1'b1, 1'b1})
      $display("FAIL single_grant: grant=%b id=%0d rom=%0b busy=%0b want 0010/1/1/1",
               grant, grant_id, ROMsel, busy);
    else pass_cnt++;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ROMsel) hi++; else break;
    end
    chk_cnt++;
    if (hi !== 14) $display("FAIL single_window_len: got %0d want 14", hi);
    else pass_cnt++;
    chk_cnt++;
    if ({done, grant, grant_id, busy} !== {4'b0010, 4'b0000, 2'd1, 1'b1})
      $display("FAIL single_done: done=%b grant=%b id=%0d busy=%0b want 0010/0000/1/1",
               done, grant, grant_id, busy);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({done, busy, ROMsel, grant_id} !== {4'b0000, 1'b0, 1'b0, 2'd1})
      $display("FAIL single_after_guard: done=%b busy=%0b rom=%0b id=%0d want 0000/0/0/1",
               done, busy, ROMsel, grant_id);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({ROMsel, grant} !== {1'b1, 4'b0010})
      $display("FAIL single_regrant: rom=%0b grant=%b want 1/0010", ROMsel, grant);
    else pass_cnt++;
    req = 4'b0000;
    wait_idle("single");
  endtask

  task automatic test_rotate();
    int exp_ids[4] = '{0, 1, 3, 0};
    int cyc = 0;
    int last_t = 0;
    bit prev, found;
    do_reset();
    req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int n = 0; n < 40; n++) begin
        prev = ROMsel;
        step();
        cyc++;
        if (ROMsel && !prev) begin found = 1'b1; break; end
      end
      chk_cnt++;
      if (!found || int'(grant_id) !== exp_ids[k])
        $display("FAIL rotate_owner%0d: found=%0b id=%0d want %0d", k, found, grant_id, exp_ids[k]);
      else pass_cnt++;
      if (k > 0) begin
        chk_cnt++;
        if (cyc - last_t !== 16) $display("FAIL rotate_gap%0d: got %0d want 16", k, cyc - last_t);
        else pass_cnt++;
      end
      last_t = cyc;
    end
    req = 4'b0000;
    wait_idle("rotate");
  endtask

  task automatic test_drop();
    int hi = 1;
    int bad = 0;
    do_reset();
    req = 4'b0100;
    step();
    chk_cnt++;
    if ({ROMsel, grant_id} !== {1'b1, 2'd2})
      $display("FAIL drop_grant: rom=%0b id=%0d want 1/2", ROMsel, grant_id);
    else pass_cnt++;
    for (int k = 0; k < 20; k++) begin
      if (hi == 5) req = 4'b0000;
      step();
      if (ROMsel) hi++; else break;
    end
    chk_cnt++;
    if (hi !== 14) $display("FAIL drop_window_len: got %0d want 14", hi);
    else pass_cnt++;
    chk_cnt++;
    if (done !== 4'b0100) $display("FAIL drop_done: got %b want 0100", done);
    else pass_cnt++;
    step();
    repeat (10) begin
      step();
      if ({busy, ROMsel, grant, done} !== 10'h0) bad++;
    end
    chk_cnt++;
    if (bad !== 0) $display("FAIL drop_stays_idle: %0d busy cycles, want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_clear_mid();
    do_reset();
    req = 4'b0001;
    step();
    repeat (7) step();
    chk_cnt++;
    if ({ROMsel, grant} !== {1'b1, 4'b0001})
      $display("FAIL clear_pre: rom=%0b grant=%b want 1/0001", ROMsel, grant);
    else pass_cnt++;
    Clear = 1'b1;
    #1;
    chk_cnt++;
    if ({ROMsel, grant, busy, done} !== 10'h0)
      $display("FAIL clear_async: rom=%0b grant=%b busy=%0b done=%b want all 0",
               ROMsel, grant, busy, done);
    else pass_cnt++;
    step();
    Clear = 1'b0;
    req = 4'b1000;
    chk_cnt++;
    if (done !== 4'b0000) $display("FAIL clear_no_done: got %b want 0000", done);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({grant, grant_id, ROMsel} !== {4'b1000, 2'd3, 1'b1})
      $display("FAIL clear_regrant: grant=%b id=%0d rom=%0b want 1000/3/1", grant, grant_id, ROMsel);
    else pass_cnt++;
    req = 4'b0000;
    wait_idle("clear");
  endtask

  task automatic test_w1();
    logic [3:0] e;
    do_reset();
    req_w1 = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      e = 4'b0001 << (k / 2);
      chk_cnt++;
      if (k % 2 == 0) begin
        if ({rom_w1, grant_w1, gid_w1} !== {1'b1, e, 2'(k / 2)})
          $display("FAIL w1_grant%0d: rom=%0b grant=%b id=%0d want 1/%b/%0d",
                   k, rom_w1, grant_w1, gid_w1, e, k / 2);
        else pass_cnt++;
      end else begin
        if ({rom_w1, done_w1, busy_w1} !== {1'b0, e, 1'b0})
          $display("FAIL w1_done%0d: rom=%0b done=%b busy=%0b want 0/%b/0",
                   k, rom_w1, done_w1, busy_w1, e);
        else pass_cnt++;
      end
    end
    req_w1 = 4'b0000;
  endtask

  task automatic test_n1();
    int rises = 0;
    int bad = 0;
    bit prev;
    do_reset();
    req_n1 = 1'b1;
    repeat (30) begin
      prev = rom_n1;
      step();
      if (rom_n1 && !prev) rises++;
      if (gid_n1 !== 1'b0 || grant_n1 !== rom_n1) bad++;
    end
    chk_cnt++;
    if (rises !== 5) $display("FAIL n1_windows: got %0d want 5", rises);
    else pass_cnt++;
    chk_cnt++;
    if (bad !== 0) $display("FAIL n1_grant_id: %0d bad cycles, want 0", bad);
    else pass_cnt++;
    req_n1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_rotate();
    test_drop();
    test_clear_mid();
    test_w1();
    test_n1();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rom_window_arbiter.md
Name: rom_window_arbiter

Overview:
- Shares the processor's function ROM/MUX path between N_REQ requesters (fetch, ALU function unit, loader, ...).
- Grants one requester at a time for a fixed ROM window of WINDOW cycles, driving ROMsel and the source select for that window.
- Inserts GUARD idle cycles between windows and picks the next owner round-robin.
- Sits between requester control logic and the function ROM/MUX datapath; the datapath sees only ROMsel and grant_id.

Parameters:
- N_REQ, 4, number of requesters; legal range 1..8.
- WINDOW, 14, cycles ROMsel is held per grant (count 0..13); must be >= 1.
- GUARD, 1, idle cycles after each window before re-arbitration; must be >= 0.

Ports:
- Clk  input  1  system clock, rising edge.
- Clear  input  1  reset, asynchronous, active-high.
- req  input  N_REQ  level request per requester.
- grant  output  N_REQ  one-hot owner of the current window; all zero otherwise.
- grant_id  output  max(1,$clog2(N_REQ))  binary index of the current/last owner; drives the MUX select.
- ROMsel  output  1  high for exactly WINDOW cycles per grant.
- done  output  N_REQ  one-cycle one-hot pulse to the owner when its window ends.
- busy  output  1  high in WINDOW and GUARD states.

Behaviour:
- Reset (Clear=1, async): state=IDLE; grant=0; ROMsel=0; done=0; busy=0; grant_id=0; count=0; rr pointer=N_REQ-1, so req[0] wins first.
- Clear mid-window aborts immediately: no done pulse, and ROMsel drops asynchronously.
- States: IDLE, WINDOW, GUARD (enum in package).
- IDLE:
  - If req==0, stay.
  - Otherwise, at the next edge: winner = first set bit searching from ptr+1 upward with wrap-around.
  - At that edge: grant=onehot(winner), grant_id=winner, ROMsel=1, count=0, ptr=winner, state=WINDOW.
  - Latency from req seen high in IDLE to ROMsel high: 1 edge.
- WINDOW:
  - count increments each edge.
  - At the edge where count==WINDOW-1: ROMsel=0, grant=0, done[owner]=1 for one cycle, count=0.
  - Next state is GUARD if GUARD>0, else IDLE.
  - ROMsel is therefore high for exactly WINDOW consecutive cycles.
  - req changes during WINDOW, including the owner dropping its req, are ignored; the window always runs full length.
- GUARD: counts GUARD cycles, then goes to IDLE. done is cleared after its single cycle. The arbiter does not sample req here.
- grant_id holds the last owner's value outside windows; it is not cleared.
- Back-to-back throughput: one window per WINDOW+GUARD+1 cycles under continuous requests.
- Fairness: with all req held high, owners rotate 0,1,...,N_REQ-1,0,...
- A requester that drops req before being granted loses its turn; no request is remembered.
- N_REQ=1: always grants index 0. grant_id width is 1.
- count width is max(1,$clog2(WINDOW)); GUARD counter is sized the same way from GUARD. No overflow is possible by construction.
- All outputs are registered except that Clear forces them low asynchronously.

Decomposition:
- Package rom_arb_pkg:
  - state typedef (IDLE/WINDOW/GUARD);
  - default constants DEF_WINDOW=14, DEF_GUARD=1, MAX_REQ=8.
- Sub-module rr_priority_picker: combinational; inputs req and ptr; outputs winner index and a valid bit.
- rom_window_arbiter instantiates one rr_priority_picker. The FSM and counters stay in the top module.

Test Plan:
- Single request: after reset, hold req=4'b0010 -> one edge later grant=0010, grant_id=1, ROMsel high 14 cycles. done=0010 for 1 cycle, then 1 guard cycle, then a new grant because req is still high.
- Simultaneous requests: req=4'b1011 held -> grants in order 0,1,3,0. Consecutive ROMsel rising edges are 16 cycles apart (14+1+1).
- Drop during window: req[2] asserted alone, deasserted at cycle 5 of its window -> ROMsel stays high all 14 cycles, done[2] pulses, then the arbiter idles.
- Reset mid-window: Clear pulsed at count=7 -> ROMsel, grant and busy go low immediately with no done pulse. After release with req=4'b1000, index 3 is granted and the pointer restarts from N_REQ-1.
- Parameter corners:
  - WINDOW=1, GUARD=0 with req=4'b1111 -> ROMsel high 1 of every 2 cycles, owners rotate 0..3.
  - N_REQ=1 -> grant_id is always 0.
- Idle check: req=0 for 50 cycles after reset -> all outputs stay 0 and busy=0.
